// File: rtl/cmp_pkg.sv
// Shared definitions for the shared-comparator arbiter: index width helper
// and the {lesser,greater,equal} result encoding.
package cmp_pkg;

    localparam logic [2:0] CMP_LT = 3'b100;
    localparam logic [2:0] CMP_GT = 3'b010;
    localparam logic [2:0] CMP_EQ = 3'b001;

    typedef logic [2:0] cmp_res_t;

    // Requester index width; a single requester still needs one bit.
    function automatic int idw_f(input int r);
        return (r > 1) ? $clog2(r) : 1;
    endfunction

endpackage

// File: rtl/cmp_share_arbiter_if.sv
// Client-facing bus of the shared comparator: per-requester operands in,
// grants and tagged registered results out.
interface cmp_share_arbiter_if #(
    parameter int N = 8,
    parameter int R = 4
);
    localparam int IDW = cmp_pkg::idw_f(R);

    logic               en;
    logic [R-1:0]       req;
    logic [R*N-1:0]     a_flat;
    logic [R*N-1:0]     b_flat;
    logic [R-1:0]       gnt;
    logic [R-1:0]       rsp_valid;
    logic [IDW-1:0]     rsp_id;
    logic               lesser;
    logic               greater;
    logic               equal;

    modport master (
        output en, req, a_flat, b_flat,
        input  gnt, rsp_valid, rsp_id, lesser, greater, equal
    );

    modport slave (
        input  en, req, a_flat, b_flat,
        output gnt, rsp_valid, rsp_id, lesser, greater, equal
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping,
// gated by en.
module rr_arbiter
    import cmp_pkg::*;
#(
    parameter  int R   = 4,
    localparam int IDW = idw_f(R)
) (
    input  logic [R-1:0]   req,
    input  logic           en,
    input  logic [IDW-1:0] ptr,
    output logic [R-1:0]   gnt,
    output logic [IDW-1:0] win,
    output logic           any
);

    int idx;

    always_comb begin
        gnt = '0;
        win = '0;
        any = 1'b0;
        idx = 0;
        for (int k = 0; k < R; k++) begin
            // ptr is always < R, so a single wrap is enough
            idx = int'(ptr) + k;
            if (idx >= R) idx = idx - R;
            if (en && !any && req[idx]) begin
                any      = 1'b1;
                win      = IDW'(idx);
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cmp_share_arbiter.sv
// One unsigned magnitude comparator time-shared among R requesters; the
// granted pair is compared and the tagged result registered one cycle later.
module cmp_share_arbiter
    import cmp_pkg::*;
#(
    parameter int N = 8,
    parameter int R = 4
) (
    input  logic              clk,
    input  logic              rst,
    cmp_share_arbiter_if.slave bus
);

    localparam int IDW = idw_f(R);

    logic [R-1:0]   gnt;
    logic [IDW-1:0] win;
    logic           any;

    logic [IDW-1:0] ptr_q, ptr_d;
    logic [R-1:0]   rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    cmp_res_t       res_q, res_d;

    int             sel_base;
    logic [N-1:0]   a_sel, b_sel;
    cmp_res_t       cmp_res;

    rr_arbiter #(.R(R)) u_arb (
        .req (bus.req),
        .en  (bus.en),
        .ptr (ptr_q),
        .gnt (gnt),
        .win (win),
        .any (any)
    );

    // Operand mux in front of the single comparator
    assign sel_base = int'(win) * N;
    assign a_sel    = bus.a_flat[sel_base +: N];
    assign b_sel    = bus.b_flat[sel_base +: N];

    always_comb begin
        if (a_sel < b_sel)      cmp_res = CMP_LT;
        else if (a_sel > b_sel) cmp_res = CMP_GT;
        else                    cmp_res = CMP_EQ;
    end

    always_comb begin
        ptr_d       = ptr_q;
        rsp_id_d    = rsp_id_q;
        res_d       = res_q;
        rsp_valid_d = '0;
        if (any) begin
            ptr_d       = (win == IDW'(R - 1)) ? '0 : win + 1'b1;
            rsp_id_d    = win;
            res_d       = cmp_res;
            rsp_valid_d = gnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            rsp_valid_q <= '0;
            rsp_id_q    <= '0;
            res_q       <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            res_q       <= res_d;
        end
    end

    assign bus.gnt       = gnt;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.lesser    = res_q[2];
    assign bus.greater   = res_q[1];
    assign bus.equal     = res_q[0];

    a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_res_onehot: assert property (@(posedge clk) disable iff (rst)
                                   (rsp_valid_q != '0) |-> $onehot(res_q));

endmodule

// File: doc/cmp_share_arbiter.md
# cmp_share_arbiter

Round-robin arbiter and sequencer that shares one N-bit magnitude comparator among R requesters. Each requester presents an operand pair with a request. The block grants one requester per cycle, compares that requester's pair, and returns a registered lesser/greater/equal result tagged with the requester index one cycle later. It sits between the client blocks that need unsigned comparisons and a single comparator datapath, which saves area over per-client comparators.

## Interface
Parameters:
- N, 8, operand width in bits (≥1).
- R, 4, number of requesters (≥1).

Ports:
- clk  in  1  sole clock; everything samples on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  when low, no grants issue; the result pipeline still drains.
- req  in  R  per-requester request; bit i asserted means a_flat/b_flat slice i is valid.
- a_flat  in  R*N  operand A per requester; slice i is bits [i*N +: N].
- b_flat  in  R*N  operand B per requester, same slicing.
- gnt  out  R  one-hot or zero, combinational; bit i high means requester i's pair is consumed at this edge.
- rsp_valid  out  R  one-hot or zero, registered; one-cycle pulse to the requester whose result is on the result bus.
- rsp_id  out  IDW  binary index of the requester owning the current result; IDW = (R>1) ? $clog2(R) : 1.
- lesser  out  1  registered, A < B (unsigned).
- greater  out  1  registered, A > B (unsigned).
- equal  out  1  registered, A == B.

## Operation
- Round-robin pointer ptr (IDW bits), reset 0. Search order is ptr, ptr+1, …, R-1, 0, …, ptr-1. The first index with req set wins.
- gnt = one-hot(winner) when en && |req; otherwise 0. Purely combinational from req, en and ptr.
- On an edge with a grant to i:
  - ptr ← (i+1) mod R.
  - the comparator evaluates slice i of a_flat/b_flat; lesser/greater/equal are registered.
  - rsp_id ← i, rsp_valid ← one-hot(i).
- On an edge with no grant: rsp_valid ← 0. lesser/greater/equal/rsp_id hold their last values. ptr holds.
- Exactly one of lesser/greater/equal is high whenever rsp_valid ≠ 0. Comparison is unsigned at full width N, with no truncation.
- Handshake:
  - A requester holds req and its operands stable until it sees its gnt bit high, then may drop req or present a new pair the next cycle.
  - Withdrawing req before a grant is legal and produces no result.
  - There is no response backpressure; the requester must capture the result in the rsp_valid cycle.
- Throughput is one comparison per cycle. Back-to-back grants to the same requester only happen when it is the sole requester.
- R = 1: ptr stays 0; gnt = req & en.

## Timing
- Grant to result: gnt high in cycle k → rsp_valid/result valid in cycle k+1 (latency 1).
- Reset values (asynchronous, immediate): ptr=0, rsp_valid=0, rsp_id=0, lesser=0, greater=0, equal=0. gnt is then determined combinationally with ptr=0.
- Reset asserted mid-operation: any result due next cycle is dropped, with no rsp_valid pulse. The first post-reset grant follows the ptr=0 order.
- en falling in the same cycle as a pending result: that result still appears (pipeline drains); no new grant issues.
- A requester raising req in the same cycle another is granted waits for the next arbitration cycle under the updated ptr.

## Structure
- Shared package cmp_pkg holds:
  - the function for IDW (clog2 with a floor of 1);
  - the result encoding constants CMP_LT=3'b100, CMP_GT=3'b010, CMP_EQ=3'b001, in {lesser,greater,equal} order, for benches and clients.
- One sub-module, rr_arbiter #(R): takes req, en and ptr; returns gnt and winner index. The top holds ptr, the operand mux, the comparison and the result registers.

## Test plan
- Reset then idle: rst pulse mid-run with req=0 → all outputs 0, rsp_valid never pulses, ptr=0 (next grant to requester 0 when req=4'b1111).
- Fairness: R=4, req=4'b1111 held 8 cycles → gnt sequence 0,1,2,3,0,1,2,3; rsp_id one cycle behind.
- Compare values, N=8:
  - requester 2 with A=8'h7F, B=8'h80 → lesser=1;
  - requester 1 with A=8'hFF, B=8'h00 → greater=1;
  - requester 3 with A=B=8'hA5 → equal=1.
  - Each with rsp_valid only on its own bit.
- Pointer skip: ptr=1, req=4'b1001 → gnt=4'b1000, then ptr=0, next gnt=4'b0001.
- en gating: req=4'b0010, en=0 for 3 cycles → gnt=0, no rsp_valid. en=1 → gnt=4'b0010 that cycle, result the next.
- Reset mid-operation: grant to requester 2 in cycle k, rst asserted during cycle k → no rsp_valid in k+1, outputs 0, ptr=0.
